// File: rtl/serializer_pkg.sv
// Shared types and helpers for the operand serializer.
package serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Beat counter width: clog2(msb + 1), never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned msb);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < (msb + 32'd1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dual_shift_reg.sv
// Two parallel-load, left-shift registers sharing load/shift enables; MSB taps out.
module dual_shift_reg #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] a_load,
    input  logic [W-1:0] b_load,
    output logic         a_msb,
    output logic         b_msb
);

    logic [W-1:0] a_q;
    logic [W-1:0] b_q;

    // Load has priority over shift; shifting fills with zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q <= '0;
            b_q <= '0;
        end else if (load) begin
            a_q <= a_load;
            b_q <= b_load;
        end else if (shift) begin
            a_q <= a_q << 1;
            b_q <= b_q << 1;
        end
    end

    assign a_msb = a_q[W-1];
    assign b_msb = b_q[W-1];

endmodule

// File: rtl/operand_serializer.sv
// Serializes an operand pair MSB-first, one bit of each per beat, with
// valid/ready on both sides. Optional macro SERIALIZER_EARLY_TERM_EN ends the
// pair at the first beat where the A and B bits differ.
module operand_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned n = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [n:0] a_in,
    input  logic [n:0] b_in,
    output logic       ser_valid,
    input  logic       ser_ready,
    output logic       ser_a,
    output logic       ser_b,
    output logic       ser_first,
    output logic       ser_last,
    output logic       done
);

    localparam int unsigned W  = n + 1;
    localparam int unsigned CW = cnt_width(n);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          in_ready_q;
    logic          ser_valid_q;
    logic          first_q;
    logic          last_q;
    logic          done_q;
    logic          a_msb;
    logic          b_msb;
    logic          in_hs;
    logic          beat_acc;

    assign in_hs    = in_valid && in_ready_q && (state == IDLE);
    assign beat_acc = ser_valid_q && ser_ready;

    dual_shift_reg #(
        .W (W)
    ) u_shift (
        .clk    (clk),
        .reset  (reset),
        .load   (in_hs),
        .shift  (beat_acc),
        .a_load (a_in),
        .b_load (b_in),
        .a_msb  (a_msb),
        .b_msb  (b_msb)
    );

    // Control FSM: capture, beat counting and the done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            in_ready_q  <= 1'b0;
            ser_valid_q <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                    if (in_hs) begin
                        state       <= SHIFT;
                        cnt         <= CW'(n);
                        in_ready_q  <= 1'b0;
                        ser_valid_q <= 1'b1;
                        first_q     <= 1'b1;
                        last_q      <= (n == 32'd0);
                    end
                end
                SHIFT: begin
                    if (beat_acc) begin
                        first_q <= 1'b0;
                        if (ser_last) begin
                            state       <= DONE;
                            cnt         <= '0;
                            ser_valid_q <= 1'b0;
                            last_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            cnt    <= cnt - 1'b1;
                            last_q <= (cnt == CW'(1));
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    done_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    ser_valid_q <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef SERIALIZER_EARLY_TERM_EN
    // A differing bit pair decides the comparison, so it ends the pair.
    assign ser_last = last_q || (ser_valid_q && (a_msb != b_msb));
`else
    assign ser_last = last_q;
`endif

    assign in_ready  = in_ready_q;
    assign ser_valid = ser_valid_q;
    assign ser_a     = ser_valid_q && a_msb;
    assign ser_b     = ser_valid_q && b_msb;
    assign ser_first = first_q;
    assign done      = done_q;

endmodule

// File: tb/tb_operand_serializer.sv
// Randomized and directed bench for operand_serializer (n=3 and n=0 instances).
module tb_operand_serializer;

    localparam int unsigned N = 3;
`ifdef SERIALIZER_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct packed {
        logic a;
        logic b;
        logic first;
        logic last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;

    logic       in_valid = 1'b0, in_ready, ser_valid, ser_ready, ser_a, ser_b, ser_first, ser_last, done;
    logic [N:0] a_in = '0, b_in = '0;
    logic       z_in_valid = 1'b0, z_in_ready, z_ser_valid, z_ser_a, z_ser_b, z_ser_first, z_ser_last, z_done;
    logic       z_ser_ready = 1'b1;
    logic [0:0] z_a_in = '0, z_b_in = '0;

    operand_serializer #(.n(N)) dut (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .ser_valid(ser_valid), .ser_ready(ser_ready),
        .ser_a(ser_a), .ser_b(ser_b), .ser_first(ser_first), .ser_last(ser_last), .done(done)
    );

    operand_serializer #(.n(0)) dut0 (
        .clk(clk), .reset(rst_n), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .a_in(z_a_in), .b_in(z_b_in), .ser_valid(z_ser_valid), .ser_ready(z_ser_ready),
        .ser_a(z_ser_a), .ser_b(z_ser_b), .ser_first(z_ser_first), .ser_last(z_ser_last), .done(z_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ready driver: 0 = hold ready_hold, 1 = pattern 1,0,0 repeating, 2 = random
    int   ready_mode = 0;
    int   rpos = 0;
    logic ready_hold = 1'b1;
    always @(negedge clk) begin
        case (ready_mode)
            1: begin ser_ready = ((rpos % 3) == 0); rpos++; end
            2: ser_ready = 1'($urandom_range(0, 1));
            default: ser_ready = ready_hold;
        endcase
    end

    // Reference model: phase 3 = in reset / just released, 0 = accepting,
    // 1 = sending queued beats, 2 = done pulse.
    int    m_phase = 3;
    int    m_beats = 0;
    beat_t mq[$];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 3;
            mq.delete();
        end else begin
            case (m_phase)
                3: m_phase = 0;
                0: if (in_valid) begin
                    for (int i = int'(N); i >= 0; i--) begin
                        beat_t bt;
                        bt.a     = a_in[i];
                        bt.b     = b_in[i];
                        bt.first = (i == int'(N));
                        bt.last  = (i == 0) || (EARLY && (a_in[i] != b_in[i]));
                        mq.push_back(bt);
                        if (bt.last) break;
                    end
                    m_phase = 1;
                end
                1: if (ser_ready) begin
                    beat_t bt;
                    bt = mq.pop_front();
                    m_beats++;
                    if (bt.last) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Per-cycle comparison of the n=3 instance against the model.
    always @(negedge clk) begin
        chk1("in_ready", in_ready, m_phase == 0);
        chk1("ser_valid", ser_valid, m_phase == 1);
        chk1("done", done, m_phase == 2);
        if (m_phase == 1 && mq.size() > 0) begin
            chk1("ser_a", ser_a, mq[0].a);
            chk1("ser_b", ser_b, mq[0].b);
            chk1("ser_first", ser_first, mq[0].first);
            chk1("ser_last", ser_last, mq[0].last);
        end else if (m_phase == 3) begin
            chk1("rst_ser_a", ser_a, 1'b0);
            chk1("rst_ser_b", ser_b, 1'b0);
            chk1("rst_ser_first", ser_first, 1'b0);
            chk1("rst_ser_last", ser_last, 1'b0);
        end
    end

    // Monitor of accepted beats, handshakes and done pulses.
    beat_t cap[$];
    beat_t zcap[$];
    int    cap_cyc[$], done_cyc[$], hs_cyc[$];
    int    cyc = 0;
    int    zdone = 0;
    always @(posedge clk) begin
        if (rst_n) begin
            if (ser_valid && ser_ready) begin
                cap.push_back(beat_t'({ser_a, ser_b, ser_first, ser_last}));
                cap_cyc.push_back(cyc);
            end
            if (done) done_cyc.push_back(cyc);
            if (in_valid && in_ready) hs_cyc.push_back(cyc);
            if (z_ser_valid && z_ser_ready) zcap.push_back(beat_t'({z_ser_a, z_ser_b, z_ser_first, z_ser_last}));
            if (z_done) zdone++;
        end
        cyc++;
    end

    task automatic clr();
        cap.delete(); cap_cyc.delete(); done_cyc.delete(); hs_cyc.delete();
        zcap.delete(); zdone = 0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #1 rst_n = 1'b0;
        in_valid = 1'b0;
        z_in_valid = 1'b0;
        #1;
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_z_in_ready", z_in_ready, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk1("in_ready_after_rst", in_ready, 1'b1);
        chk1("z_in_ready_after_rst", z_in_ready, 1'b1);
    endtask

    task automatic send_pair(input logic [N:0] a, input logic [N:0] b);
        bit got = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; a_in = a; b_in = b;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk);
            if (in_ready) got = 1'b1;
        end
        chk1("input_handshake", got, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        a_in = (N+1)'($urandom);
        b_in = (N+1)'($urandom);
    endtask

    task automatic wait_done(input int cnt, input int budget);
        for (int k = 0; k < budget && done_cyc.size() < cnt; k++) @(negedge clk);
        chk_int("done_count", done_cyc.size(), cnt);
    endtask

    // Beat i of the pair corresponds to bit (3-i) of the expectation vectors.
    task automatic check_beats(input string tag, input int nb, input logic [3:0] ea, input logic [3:0] eb,
                               input logic [3:0] ef, input logic [3:0] el);
        chk_int({tag, "_beats"}, cap.size(), nb);
        for (int i = 0; i < nb && i < cap.size(); i++) begin
            chk1({tag, "_a"}, cap[i].a, ea[3-i]);
            chk1({tag, "_b"}, cap[i].b, eb[3-i]);
            chk1({tag, "_first"}, cap[i].first, ef[3-i]);
            chk1({tag, "_last"}, cap[i].last, el[3-i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int       t1_nb, t3_nb;
        logic [3:0] t1_a, t1_b, t1_f, t1_l, t3_a, t3_b, t3_f, t3_l;
        bit       got;
`ifdef SERIALIZER_EARLY_TERM_EN
        t1_nb = 3; t1_a = 4'b1010; t1_b = 4'b1000; t1_f = 4'b1000; t1_l = 4'b0010;
        t3_nb = 2; t3_a = 4'b1100; t3_b = 4'b1000; t3_f = 4'b1000; t3_l = 4'b0100;
`else
        t1_nb = 4; t1_a = 4'b1011; t1_b = 4'b1001; t1_f = 4'b1000; t1_l = 4'b0001;
        t3_nb = 4; t3_a = 4'b1100; t3_b = 4'b1000; t3_f = 4'b1000; t3_l = 4'b0001;
`endif
        ready_hold = 1'b1;
        reset_dut();

        // Basic pair with ready held high.
        clr();
        send_pair(4'b1011, 4'b1001);
        wait_done(1, 20);
        check_beats("t1", t1_nb, t1_a, t1_b, t1_f, t1_l);
        if (hs_cyc.size() > 0 && cap_cyc.size() > 0)
            chk_int("t1_first_latency", cap_cyc[0] - hs_cyc[0], 1);
        if (done_cyc.size() > 0 && cap_cyc.size() > 0)
            chk_int("t1_done_latency", done_cyc[0] - cap_cyc[cap_cyc.size()-1], 1);

        // Same pair with stalls.
        repeat (2) @(negedge clk);
        clr();
        rpos = 0;
        ready_mode = 1;
        send_pair(4'b1011, 4'b1001);
        wait_done(1, 40);
        check_beats("t2", t1_nb, t1_a, t1_b, t1_f, t1_l);
        ready_mode = 0;

        // Pair differing at the second bit.
        repeat (2) @(negedge clk);
        clr();
        send_pair(4'b1100, 4'b1000);
        wait_done(1, 20);
        check_beats("t3", t3_nb, t3_a, t3_b, t3_f, t3_l);

        // Reset during SHIFT after two beats.
        repeat (2) @(negedge clk);
        clr();
        send_pair(4'b1101, 4'b1100);
        for (int k = 0; k < 20 && cap.size() < 2; k++) begin
            @(posedge clk);
            #1;
        end
        chk_int("t4_beats_before_rst", cap.size(), 2);
        #1 rst_n = 1'b0;
        #1;
        chk1("t4_in_ready", in_ready, 1'b0);
        chk1("t4_ser_valid", ser_valid, 1'b0);
        chk1("t4_ser_a", ser_a, 1'b0);
        chk1("t4_ser_b", ser_b, 1'b0);
        chk1("t4_ser_first", ser_first, 1'b0);
        chk1("t4_ser_last", ser_last, 1'b0);
        chk1("t4_done", done, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk1("t4_ready_after_release", in_ready, 1'b1);
        repeat (8) @(negedge clk);
        chk_int("t4_no_done", done_cyc.size(), 0);
        chk_int("t4_no_more_beats", cap.size(), 2);

        // Single-bit instance.
        clr();
        @(negedge clk);
        z_in_valid = 1'b1; z_a_in = 1'b1; z_b_in = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk);
            if (z_in_ready) got = 1'b1;
        end
        chk1("t5_handshake", got, 1'b1);
        @(negedge clk);
        z_in_valid = 1'b0; z_a_in = 1'b0;
        for (int k = 0; k < 10 && zdone == 0; k++) @(negedge clk);
        chk_int("t5_beats", zcap.size(), 1);
        chk_int("t5_done", zdone, 1);
        if (zcap.size() > 0) begin
            chk1("t5_a", zcap[0].a, 1'b1);
            chk1("t5_b", zcap[0].b, 1'b0);
            chk1("t5_first", zcap[0].first, 1'b1);
            chk1("t5_last", zcap[0].last, 1'b1);
        end

        // Back-to-back pairs with in_valid held high.
        repeat (2) @(negedge clk);
        clr();
        in_valid = 1'b1;
        for (int p = 0; p < 5; p++) begin
            a_in = (N+1)'($urandom);
            b_in = a_in;
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(posedge clk);
                if (in_ready) got = 1'b1;
            end
            chk1("t6_handshake", got, 1'b1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_done(5, 20);
        chk_int("t6_beats", cap.size(), 5 * int'(N + 1));
        for (int p = 1; p < hs_cyc.size(); p++)
            chk_int("t6_spacing", hs_cyc[p] - hs_cyc[p-1], int'(N) + 3);

        // Random traffic checked cycle by cycle against the model.
        repeat (2) @(negedge clk);
        clr();
        m_beats = 0;
        ready_mode = 2;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            a_in = (N+1)'($urandom);
            b_in = ($urandom_range(0, 2) == 0) ? a_in : (N+1)'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        ready_mode = 0;
        ready_hold = 1'b1;
        repeat (20) @(negedge clk);
        chk_int("t7_beats", cap.size(), m_beats);
        chk_int("t7_pairs_done", done_cyc.size(), hs_cyc.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_serializer.md
OPERAND_SERIALIZER -- requirements
Module: operand_serializer

Interface
REQ-001 SHALL have parameter n, default 3, MSB index; operand width is n+1, n >= 0.
REQ-002 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset (clears on reset=0, independent of clk).
REQ-004 SHALL have port in_valid, input, 1, parallel operand pair offered.
REQ-005 SHALL have port in_ready, output, 1, block can accept an operand pair.
REQ-006 SHALL have port a_in, input, n+1, operand A.
REQ-007 SHALL have port b_in, input, n+1, operand B.
REQ-008 SHALL have port ser_valid, output, 1, serial beat present.
REQ-009 SHALL have port ser_ready, input, 1, downstream serial comparator accepts the beat.
REQ-010 SHALL have port ser_a, output, 1, current bit of A, MSB-first.
REQ-011 SHALL have port ser_b, output, 1, current bit of B, MSB-first.
REQ-012 SHALL have port ser_first, output, 1, beat carries bit n.
REQ-013 SHALL have port ser_last, output, 1, final beat of the operand pair.
REQ-014 SHALL have port done, output, 1, one-cycle pulse after the final beat is accepted.

Function
REQ-015 SHALL implement states IDLE, SHIFT and DONE.
REQ-016 In IDLE, in_ready SHALL be 1; in every other state it SHALL be 0.
REQ-017 An input handshake SHALL be in_valid && in_ready at a clk edge.
REQ-018 On an input handshake, the block SHALL capture a_in and b_in, load the beat counter with n, and enter SHIFT.
REQ-019 The first beat SHALL appear the cycle after the input handshake; input-to-first-beat latency is 1 clk.
REQ-020 In SHIFT, ser_valid SHALL be 1, and ser_a/ser_b SHALL present the MSB of the shifted registers.
REQ-021 A beat SHALL be accepted on ser_valid && ser_ready at a clk edge.
REQ-022 On beat acceptance, both registers SHALL shift left by one with 0 fill, and the counter SHALL decrement.
REQ-023 When ser_ready is 0, ser_a, ser_b, ser_first and ser_last SHALL hold stable; no shift or count occurs.
REQ-024 ser_first SHALL be 1 only while the counter equals n and no beat of the pair has yet been accepted.
REQ-025 ser_last SHALL be 1 while the counter equals 0.
REQ-026 When n=0, the single beat SHALL have ser_first and ser_last both 1.
REQ-027 Acceptance of the ser_last beat SHALL move the block to DONE.
REQ-028 DONE SHALL last exactly 1 cycle with done=1 and ser_valid=0, then return to IDLE.
REQ-029 Minimum throughput SHALL be n+3 clk per operand pair with ser_ready held at 1.
REQ-030 in_valid SHALL be ignored outside IDLE; a_in and b_in changes after capture SHALL have no effect.

Reset
REQ-031 When reset=0, the block SHALL asynchronously go to IDLE with the counter cleared and the operand registers cleared.
REQ-032 During reset, in_ready SHALL be 0 and ser_valid, ser_a, ser_b, ser_first, ser_last and done SHALL all be 0.
REQ-033 in_ready SHALL rise in the first cycle after reset deasserts.
REQ-034 A reset during SHIFT SHALL abort the pair; no done pulse and no further beats SHALL follow.

Configuration
REQ-035 With macro SERIALIZER_EARLY_TERM_EN defined, an accepted beat with ser_a != ser_b SHALL be flagged ser_last=1 combinationally, and its acceptance SHALL move the block to DONE.
REQ-036 With SERIALIZER_EARLY_TERM_EN defined, beats SHALL continue normally while ser_a == ser_b.
REQ-037 Without SERIALIZER_EARLY_TERM_EN, all n+1 beats SHALL always be sent, and ser_last SHALL depend on the counter only.

Structure
REQ-038 Package serializer_pkg SHALL hold the state enum (IDLE/SHIFT/DONE) and a counter-width function clog2(n+1) (minimum 1).
REQ-039 A sub-module dual_shift_reg SHALL provide two parallel-load, left-shift registers with shared load/shift enables and MSB taps.

Verification
REQ-040 Scenario: n=3, a_in=1011, b_in=1001, ser_ready=1 -> ser_a beats 1,0,1,1 and ser_b beats 1,0,0,1; first flag on beat 1; last flag on beat 4; done 1 clk later.
REQ-041 Scenario: same stimulus with ser_ready toggling 1,0,0,1,... -> bits and flags held during stalls; exactly 4 accepted beats.
REQ-042 Scenario: SERIALIZER_EARLY_TERM_EN defined, a_in=1100, b_in=1000 -> 2 beats (1/1, 1/0); the second beat has ser_last=1; done follows.
REQ-043 Scenario: reset=0 asserted mid-SHIFT after beat 2 -> outputs 0 immediately; in_ready=1 the cycle after release; no done.
REQ-044 Scenario: n=0, a_in=1, b_in=0 -> a single beat with first=last=1, then done.
REQ-045 Scenario: in_valid held high back-to-back with ser_ready=1 -> pairs separated by exactly n+3 clk; no pair lost or duplicated.
